// File: rtl/score_counter.sv
// Two-digit BCD score counter driven by short/long press events.
// Saturates or wraps at 00 and MAX_SCORE; emits change/limit pulses.
module score_counter #(
    parameter int unsigned MAX_SCORE = 99,
    parameter bit          WRAP      = 1'b0
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic       count_up,
    input  logic       count_down,
    input  logic       clear_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       changed_o,
    output logic       limit_o
);

    localparam logic [3:0] MAX_TENS = 4'(MAX_SCORE / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_SCORE % 10);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       changed_q, changed_d;
    logic       limit_q, limit_d;
    logic       up_prev_q, up_prev_d;
    logic       down_prev_q, down_prev_d;

    logic up_evt;
    logic down_evt;
    logic inc_req;
    logic dec_req;
    logic at_max;
    logic at_zero;

    always_comb begin
        up_evt   = count_up & ~up_prev_q;
        down_evt = count_down & ~down_prev_q;
        inc_req  = ~clear_i & up_evt & ~down_evt;
        dec_req  = ~clear_i & down_evt & ~up_evt;
        at_max   = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
        at_zero  = (tens_q == 4'd0) && (ones_q == 4'd0);

        tens_d      = tens_q;
        ones_d      = ones_q;
        changed_d   = 1'b0;
        limit_d     = 1'b0;
        up_prev_d   = count_up;
        down_prev_d = count_down;

        // conflicting events fall through to the hold branch
        unique case (1'b1)
            clear_i: begin
                tens_d    = 4'd0;
                ones_d    = 4'd0;
                changed_d = ~at_zero;
            end
            inc_req: begin
                if (at_max) begin
                    if (WRAP) begin
                        tens_d    = 4'd0;
                        ones_d    = 4'd0;
                        changed_d = 1'b1;
                    end else begin
                        limit_d = 1'b1;
                    end
                end else begin
                    changed_d = 1'b1;
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
            end
            dec_req: begin
                if (at_zero) begin
                    if (WRAP) begin
                        tens_d    = MAX_TENS;
                        ones_d    = MAX_ONES;
                        changed_d = 1'b1;
                    end else begin
                        limit_d = 1'b1;
                    end
                end else begin
                    changed_d = 1'b1;
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // prev flops reset high so a level held across reset is not an event
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            changed_q   <= 1'b0;
            limit_q     <= 1'b0;
            up_prev_q   <= 1'b1;
            down_prev_q <= 1'b1;
        end else begin
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            changed_q   <= changed_d;
            limit_q     <= limit_d;
            up_prev_q   <= up_prev_d;
            down_prev_q <= down_prev_d;
        end
    end

    assign tens_o    = tens_q;
    assign ones_o    = ones_q;
    assign changed_o = changed_q;
    assign limit_o   = limit_q;

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter: saturating 0..99 instance
// plus a wrapping 0..15 instance.
module tb_score_counter;

    logic clk = 1'b0;
    logic rst_n;
    logic up0, dn0, clr0;
    logic up1, dn1, clr1;
    logic [3:0] t0, o0, t1, o1;
    logic ch0, lm0, ch1, lm1;

    int total = 0;
    int passed = 0;
    int chg0 = 0;

    typedef struct {
        logic up;
        logic dn;
        logic clr;
        int   sc;
        logic ch;
        logic lm;
    } vec_t;

    vec_t vecs[19];

    score_counter #(.MAX_SCORE(99), .WRAP(1'b0)) dut0 (
        .clk_1khz  (clk),
        .rst_n     (rst_n),
        .count_up  (up0),
        .count_down(dn0),
        .clear_i   (clr0),
        .tens_o    (t0),
        .ones_o    (o0),
        .changed_o (ch0),
        .limit_o   (lm0)
    );

    score_counter #(.MAX_SCORE(15), .WRAP(1'b1)) dut1 (
        .clk_1khz  (clk),
        .rst_n     (rst_n),
        .count_up  (up1),
        .count_down(dn1),
        .clear_i   (clr1),
        .tens_o    (t1),
        .ones_o    (o1),
        .changed_o (ch1),
        .limit_o   (lm1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ch0) chg0++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    endtask

    task automatic chk0(input string nm, input int sc, input int ch,
                        input int lm);
        check({nm, " tens"}, int'(t0), sc / 10);
        check({nm, " ones"}, int'(o0), sc % 10);
        check({nm, " changed"}, int'(ch0), ch);
        check({nm, " limit"}, int'(lm0), lm);
    endtask

    task automatic chk1(input string nm, input int sc, input int ch,
                        input int lm);
        check({nm, " tens"}, int'(t1), sc / 10);
        check({nm, " ones"}, int'(o1), sc % 10);
        check({nm, " changed"}, int'(ch1), ch);
        check({nm, " limit"}, int'(lm1), lm);
    endtask

    task automatic up0_pulse();
        up0 = 1'b1; step(); up0 = 1'b0; step();
    endtask

    task automatic up1_pulse();
        up1 = 1'b1; step(); up1 = 1'b0; step();
    endtask

    task automatic dn1_pulse();
        dn1 = 1'b1; step(); dn1 = 1'b0; step();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        // {up, dn, clr, score after edge, changed, limit}, from score 01
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

        rst_n = 1'b0;
        up0 = 1'b1; dn0 = 1'b0; clr0 = 1'b0;
        up1 = 1'b0; dn1 = 1'b0; clr1 = 1'b0;
        repeat (3) step();
        chk0("reset", 0, 0, 0);
        chk1("reset w", 0, 0, 0);

        // count_up already high at release: no event
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk0($sformatf("held up %0d", i), 0, 0, 0);
        end
        up0 = 1'b0;
        step();
        chk0("held drop", 0, 0, 0);
        up0 = 1'b1;
        step();
        chk0("first up", 1, 1, 0);
        step();
        chk0("first up end", 1, 0, 0);

        for (int i = 0; i < 19; i++) begin
            up0 = vecs[i].up;
            dn0 = vecs[i].dn;
            clr0 = vecs[i].clr;
            step();
            chk0($sformatf("vec%0d", i), vecs[i].sc,
                 int'(vecs[i].ch), int'(vecs[i].lm));
        end

        // 12 wide pulses, 09 -> 10 rollover
        c0 = chg0;
        for (int i = 1; i <= 12; i++) begin
            up0 = 1'b1;
            repeat (30) step();
            up0 = 1'b0;
            repeat (20) step();
            if (i == 9 || i == 10)
                chk0($sformatf("wide %0d", i), i, 0, 0);
        end
        chk0("wide final", 12, 0, 0);
        check("wide pulse count", chg0 - c0, 12);

        repeat (87) up0_pulse();
        chk0("at 99", 99, 0, 0);
        up0 = 1'b1;
        step();
        chk0("up at max", 99, 0, 1);
        up0 = 1'b0;
        step();
        chk0("max limit end", 99, 0, 0);
        clr0 = 1'b1;
        step();
        chk0("clear 99", 0, 1, 0);
        clr0 = 1'b0;
        dn0 = 1'b1;
        step();
        chk0("down at 0", 0, 0, 1);
        dn0 = 1'b0;
        step();
        chk0("zero limit end", 0, 0, 0);

        repeat (7) up0_pulse();
        chk0("at 07", 7, 0, 0);
        up0 = 1'b1;
        dn0 = 1'b1;
        step();
        chk0("conflict", 7, 0, 0);
        up0 = 1'b0;
        dn0 = 1'b0;
        step();
        chk0("conflict after", 7, 0, 0);
        clr0 = 1'b1;
        up0 = 1'b1;
        step();
        chk0("clear with up", 0, 1, 0);
        clr0 = 1'b0;
        step();
        chk0("up consumed", 0, 0, 0);
        up0 = 1'b0;
        step();

        repeat (15) up1_pulse();
        chk1("w at 15", 15, 0, 0);
        up1 = 1'b1;
        step();
        chk1("w wrap up", 0, 1, 0);
        up1 = 1'b0;
        step();
        chk1("w wrap up end", 0, 0, 0);
        dn1 = 1'b1;
        step();
        chk1("w wrap down", 15, 1, 0);
        dn1 = 1'b0;
        step();
        repeat (10) dn1_pulse();
        chk1("w 10 down", 5, 0, 0);

        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        repeat (23) up0_pulse();
        chk0("at 23", 23, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk0("async reset", 0, 0, 0);
        chk1("async reset w", 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk0("after release", 0, 0, 0);
        up0 = 1'b1;
        step();
        chk0("post reset up", 1, 1, 0);
        up0 = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
